mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped down-counting timer; a bus responder on the processor memory bus,
//  in parallel with the 64MB memory. Answers READ/WRITE cycles that hit its
//  address window; ignores all other addresses and leaves DATA_OUT at high-Z.
//  Counts prescaled CLK ticks, flags expiry in a sticky status bit, drives IRQ.
// PARAMETERS
//  BASE_ADDR   26'h3FFFF00  word address of register 0 (window = BASE_ADDR..BASE_ADDR+7)
//  PRESC_W     16           prescaler register width (bits)
// PORTS
//  CLK       in   1    system clock, all state on rising edge
//  RST       in   1    asynchronous, active-low reset
//  ADDR      in   26   word address from processor ([`ADDRESS_INDEX_LIMIT:0])
//  DATA_IN   in   32   write data from processor ([`DATA_INDEX_LIMIT:0])
//  DATA_OUT  out  32   read data to processor; high-Z when not selected for read
//  READ      in   1    read strobe
//  WRITE     in   1    write strobe
//  IRQ       out  1    level interrupt = STATUS.expired & CTRL.irq_en
// BEHAVIOUR
//  Reset (RST=0, async): CTRL=0, LOAD=0, COUNT=0, PRESC=0, STATUS=0, presc_cnt=0,
//   rdata=0, IRQ=0, DATA_OUT=32'hzzzzzzzz. State holds while RST=0.
//  Decode: hit = (ADDR[25:3] == BASE_ADDR[25:3]); offset = ADDR[2:0].
//  Bus ops: READ=1,WRITE=0 -> read; READ=0,WRITE=1 -> write; both 1 or both 0 -> no-op.
//  Registers (offset): 0 CTRL {bit0 en, bit1 auto_reload, bit2 irq_en, rest RAZ/WI}
//   1 LOAD (32b RW)  2 COUNT (read live; write loads COUNT directly)
//   3 STATUS {bit0 expired, W1C}  4 PRESC (low PRESC_W bits RW, upper RAZ)
//   5..7 reserved: read 0, writes ignored.
//  Write: takes effect at the rising edge where WRITE=1 & hit; visible on next read.
//  Read: rdata captured at rising edge with READ=1,WRITE=0,hit (1-cycle latency);
//   DATA_OUT = rdata while READ & ~WRITE & hit, else high-Z. Read has no side effects.
//  Tick: when en=1, presc_cnt increments each CLK; when presc_cnt==PRESC a tick
//   is issued and presc_cnt->0 (PRESC=0 -> tick every cycle). en=0 -> presc_cnt held at 0.
//  Count, on tick: COUNT!=0 -> COUNT-1. COUNT==1 -> next value 0 and expired<=1.
//   At COUNT==0 on tick: auto_reload=1 -> COUNT<=LOAD; auto_reload=0 -> hold 0, en<=0.
//   LOAD=0 with auto_reload: expired set on every tick that reloads 0.
//  Precedence (same edge): bus write to COUNT beats tick decrement; bus write to
//   CTRL beats hardware en clear; expiry set beats W1C clear of STATUS.
//  Writing CTRL.en 0->1 clears presc_cnt; COUNT is not modified.
//  IRQ combinational from registered bits, no extra latency.
// STRUCTURE
//  Register offsets, CTRL bit positions, BASE_ADDR default go as `define in
//  prj_definition.v (MMIO_TIMER_* names) for sharing with firmware tests.
//  One sub-module: timer_prescaler (en, presc value in, tick out, clear in).
//  mmio_timer holds bus decode, register file, counter, read mux, tri-state.
// TESTING
//  1 Reset mid-count: en=1,COUNT=100, drop RST for 1 cycle -> all regs 0, IRQ=0, DATA_OUT=Z.
//  2 One-shot: LOAD ignored, COUNT=5,PRESC=0,CTRL=5 -> STATUS=1 & IRQ=1 after 5 ticks;
//    CTRL reads 4 (en cleared), COUNT stays 0; write STATUS=1 -> IRQ=0.
//  3 Auto-reload+prescale: LOAD=3,COUNT=3,PRESC=2,CTRL=3 -> expired at cycle 9,
//    COUNT=3 again 3 cycles later; tick period exactly 3 CLKs.
//  4 Collision: W1C STATUS on the same edge as expiry -> STATUS stays 1;
//    COUNT write on tick edge -> COUNT equals written value.
//  5 Decode: READ at BASE_ADDR-1 and BASE_ADDR+8 -> DATA_OUT Z; offset 6 read -> 0;
//    READ=WRITE=1 at offset 1 -> LOAD unchanged, DATA_OUT Z.
//  6 System: DA_VINCI program polls STATUS until 1 -> memory image unaffected by timer.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// rtl/mmio_timer_pkg.sv - shared constants and types for the memory-mapped timer
package mmio_timer_pkg;

    localparam logic [25:0] MMIO_TIMER_BASE_ADDR = 26'h3FFFF00;

    localparam logic [2:0] MMIO_TIMER_OFF_CTRL   = 3'd0;
    localparam logic [2:0] MMIO_TIMER_OFF_LOAD   = 3'd1;
    localparam logic [2:0] MMIO_TIMER_OFF_COUNT  = 3'd2;
    localparam logic [2:0] MMIO_TIMER_OFF_STATUS = 3'd3;
    localparam logic [2:0] MMIO_TIMER_OFF_PRESC  = 3'd4;

    localparam int MMIO_TIMER_CTRL_EN_BIT  = 0;
    localparam int MMIO_TIMER_CTRL_AR_BIT  = 1;
    localparam int MMIO_TIMER_CTRL_IRQ_BIT = 2;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - processor memory bus signals seen by the timer
interface mmio_timer_if;
    logic [25:0] addr;
    logic [31:0] data_in;
    logic        read;
    logic        write;
    logic        irq;

    modport master (output addr, output data_in, output read, output write, input irq);
    modport slave  (input addr, input data_in, input read, input write, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides clk into ticks every presc+1 cycles while enabled
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - down-counting timer responding to an 8-word window on the memory bus
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [25:0] BASE_ADDR = MMIO_TIMER_BASE_ADDR,
    parameter int          PRESC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_timer_if.slave       bus,
    output logic [31:0]       data_out
);

    ctrl_t              ctrl;
    logic [31:0]        load;
    logic [31:0]        count;
    logic [PRESC_W-1:0] presc;
    logic               expired;
    logic [31:0]        rdata;
    logic [31:0]        rd_mux;

    logic       hit;
    logic [2:0] off;
    logic       rd_op;
    logic       wr_op;
    logic       tick;
    logic       presc_clear;
    logic       expire_set;

    assign hit   = (bus.addr[25:3] == BASE_ADDR[25:3]);
    assign off   = bus.addr[2:0];
    assign rd_op = bus.read && !bus.write && hit;
    assign wr_op = bus.write && !bus.read && hit;

    assign presc_clear = wr_op && (off == MMIO_TIMER_OFF_CTRL)
                         && bus.data_in[MMIO_TIMER_CTRL_EN_BIT] && !ctrl.en;

    timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.en),
        .clear (presc_clear),
        .presc (presc),
        .tick  (tick)
    );

    // Expiry on the 1->0 step, or on every reload of a zero LOAD.
    assign expire_set = tick && ((count == 32'd1) ||
                                 ((count == '0) && ctrl.auto_reload && (load == '0)));

    always_comb begin
        rd_mux = '0;
        case (off)
            MMIO_TIMER_OFF_CTRL:   rd_mux[2:0] = ctrl;
            MMIO_TIMER_OFF_LOAD:   rd_mux = load;
            MMIO_TIMER_OFF_COUNT:  rd_mux = count;
            MMIO_TIMER_OFF_STATUS: rd_mux[0] = expired;
            MMIO_TIMER_OFF_PRESC:  rd_mux[PRESC_W-1:0] = presc;
            default:               rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            presc   <= '0;
            expired <= 1'b0;
            rdata   <= '0;
        end else begin
            if (tick) begin
                if (count != '0) begin
                    count <= count - 32'd1;
                end else if (ctrl.auto_reload) begin
                    count <= load;
                end else begin
                    ctrl.en <= 1'b0;
                end
            end
            if (expire_set) begin
                expired <= 1'b1;
            end

            // Bus writes come last so they override the hardware updates above.
            if (wr_op) begin
                case (off)
                    MMIO_TIMER_OFF_CTRL: begin
                        ctrl.en          <= bus.data_in[MMIO_TIMER_CTRL_EN_BIT];
                        ctrl.auto_reload <= bus.data_in[MMIO_TIMER_CTRL_AR_BIT];
                        ctrl.irq_en      <= bus.data_in[MMIO_TIMER_CTRL_IRQ_BIT];
                    end
                    MMIO_TIMER_OFF_LOAD:   load  <= bus.data_in;
                    MMIO_TIMER_OFF_COUNT:  count <= bus.data_in;
                    MMIO_TIMER_OFF_STATUS: begin
                        if (bus.data_in[0] && !expire_set) begin
                            expired <= 1'b0;
                        end
                    end
                    MMIO_TIMER_OFF_PRESC:  presc <= bus.data_in[PRESC_W-1:0];
                    default: ;
                endcase
            end

            if (rd_op) begin
                rdata <= rd_mux;
            end
        end
    end

    assign bus.irq  = expired && ctrl.irq_en;
    assign data_out = rd_op ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - self-checking bench for mmio_timer
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [25:0] BASE = MMIO_TIMER_BASE_ADDR;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mmio_timer_if bus ();
    tri1 [31:0] data_out;

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .data_out (data_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: register contents plus the prescale phase.
    bit          m_en, m_ar, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    logic [15:0] m_presc;
    int          m_phase;
    bit          m_drive;
    logic [31:0] m_rdata;

    typedef struct {
        logic [25:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] din;
        logic        exp_drive;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name);
        n_cmp++;
        if (data_out !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL %s: data_out %h, want released (Z)", name, data_out);
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:       return {29'd0, m_ie, m_ar, m_en};
            1:       return m_load;
            2:       return m_count;
            3:       return {31'd0, m_exp};
            4:       return {16'd0, m_presc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_phase = 0;
        m_drive = 0; m_rdata = 0;
    endtask

    task automatic model_edge(input logic [25:0] a, input logic rd, input logic wr,
                              input logic [31:0] d);
        bit          sel;
        int          off;
        bit          tick;
        bit          set_exp;
        logic [31:0] nc;
        bit          nen;
        sel     = (a[25:3] == BASE[25:3]);
        off     = int'(a[2:0]);
        tick    = m_en && (m_phase == int'(m_presc));
        set_exp = 0;
        nc      = m_count;
        nen     = m_en;
        m_drive = sel && rd && !wr;
        if (m_drive) m_rdata = model_read(off);
        if (tick) begin
            if (m_count != 0) begin
                nc = m_count - 1;
                set_exp = (nc == 0);
            end else if (m_ar) begin
                nc = m_load;
                set_exp = (m_load == 0);
            end else begin
                nen = 0;
            end
        end
        m_phase = (m_en && !tick) ? m_phase + 1 : 0;
        if (set_exp) m_exp = 1;
        if (sel && wr && !rd) begin
            case (off)
                0: begin nen = d[0]; m_ar = d[1]; m_ie = d[2]; end
                1: m_load = d;
                2: nc = d;
                3: if (d[0] && !set_exp) m_exp = 0;
                4: m_presc = d[15:0];
                default: ;
            endcase
        end
        m_count = nc;
        m_en    = nen;
    endtask

    task automatic bus_op(input logic [25:0] a, input logic rd, input logic wr,
                          input logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.read = rd; bus.write = wr; bus.data_in = d;
        model_edge(a, rd, wr, d);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus_op(BASE + 26'(off), 1'b0, 1'b1, d);
    endtask

    task automatic rd(input int off);
        bus_op(BASE + 26'(off), 1'b1, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(BASE, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_irq"}, {31'd0, bus.irq}, {31'd0, m_exp & m_ie});
        if (m_drive) check({tag, "_rdata"}, data_out, m_rdata);
        else         check_released({tag, "_z"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.addr = '0; bus.read = 0; bus.write = 0; bus.data_in = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.addr = '0; bus.read = 0; bus.write = 0; bus.data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a running count with the interrupt pending.
        wr(2, 32'd2); wr(0, 32'd5); idle(3);
        check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        wr(2, 32'd100); wr(0, 32'd5); idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        check_released("reset_data_out");
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < 5; o++) begin
            rd(o);
            check($sformatf("reset_reg%0d", o), data_out, 32'd0);
        end

        // Register access and address decode with the timer stopped.
        vecs[0]  = '{BASE + 26'd1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 32'd0};
        vecs[1]  = '{BASE + 26'd1, 1'b1, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001};
        vecs[2]  = '{BASE + 26'd0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0};
        vecs[3]  = '{BASE + 26'd0, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};
        vecs[4]  = '{BASE + 26'd4, 1'b0, 1'b1, 32'hFFFF_1234, 1'b0, 32'd0};
        vecs[5]  = '{BASE + 26'd4, 1'b1, 1'b0, 32'd0,         1'b1, 32'h0000_1234};
        vecs[6]  = '{BASE + 26'd6, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0};
        vecs[7]  = '{BASE + 26'd6, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};
        vecs[8]  = '{BASE - 26'd1, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0};
        vecs[9]  = '{BASE + 26'd8, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0};
        vecs[10] = '{BASE + 26'd1, 1'b1, 1'b1, 32'd0,         1'b0, 32'd0};
        vecs[11] = '{BASE + 26'd1, 1'b1, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001};
        vecs[12] = '{BASE + 26'd9, 1'b0, 1'b1, 32'd0,         1'b0, 32'd0};
        vecs[13] = '{BASE + 26'd1, 1'b1, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001};
        vecs[14] = '{BASE + 26'd2, 1'b0, 1'b1, 32'h0000_0077, 1'b0, 32'd0};
        vecs[15] = '{BASE + 26'd2, 1'b1, 1'b0, 32'd0,         1'b1, 32'h0000_0077};
        vecs[16] = '{BASE + 26'd3, 1'b0, 1'b1, 32'd1,         1'b0, 32'd0};
        vecs[17] = '{BASE + 26'd3, 1'b1, 1'b0, 32'd0,         1'b1, 32'd0};
        for (int i = 0; i < 18; i++) begin
            bus_op(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].din);
            if (vecs[i].exp_drive) check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
            else                   check_released($sformatf("vec%0d_z", i));
            check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, 32'd0);
        end

        // One-shot: five ticks to expiry, then en drops on the following tick.
        do_reset();
        wr(2, 32'd5); wr(0, 32'd5);
        idle(4);
        check("oneshot_irq_early", {31'd0, bus.irq}, 32'd0);
        idle(1);
        check("oneshot_irq", {31'd0, bus.irq}, 32'd1);
        idle(1);
        rd(0); check("oneshot_ctrl", data_out, 32'd4);
        rd(2); check("oneshot_count", data_out, 32'd0);
        rd(3); check("oneshot_status", data_out, 32'd1);
        wr(3, 32'd1);
        check("oneshot_irq_cleared", {31'd0, bus.irq}, 32'd0);

        // Auto-reload with a 3-cycle tick period.
        do_reset();
        wr(1, 32'd3); wr(2, 32'd3); wr(4, 32'd2); wr(0, 32'd3);
        idle(8);
        rd(3); check("ar_status_c8", data_out, 32'd0);
        rd(3); check("ar_status_c9", data_out, 32'd1);
        rd(2); check("ar_count_c10", data_out, 32'd0);
        rd(2); check("ar_count_c11", data_out, 32'd0);
        rd(2); check("ar_count_c12", data_out, 32'd3);

        // Same-edge collisions.
        do_reset();
        wr(2, 32'd2); wr(0, 32'd1); idle(1);
        wr(3, 32'd1);
        rd(3); check("coll_w1c_vs_expiry", data_out, 32'd1);
        do_reset();
        wr(2, 32'd10); wr(0, 32'd1); idle(1);
        wr(2, 32'h55);
        rd(2); check("coll_count_write", data_out, 32'h55);
        do_reset();
        wr(2, 32'd1); wr(0, 32'd1); idle(1);
        wr(0, 32'd1);
        rd(0); check("coll_ctrl_write", data_out, 32'd1);
        rd(0); check("coll_ctrl_hw_clear", data_out, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int          r;
            int          off;
            logic [31:0] d;
            r   = int'($urandom_range(0, 9));
            off = int'($urandom_range(0, 7));
            d   = $urandom;
            if (off == 1 || off == 2) d = 32'($urandom_range(0, 6));
            if (off == 4) d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            case (r)
                0, 1, 2, 3: rd(off);
                4, 5, 6:    wr(off, d);
                7:          idle(1);
                8:          bus_op(BASE + 26'd8 + 26'(off), r[0] ? 1'b1 : 1'b0, 1'b1, d);
                default:    bus_op(BASE + 26'(off), 1'b1, 1'b1, d);
            endcase
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
